// File: rtl/seq_serializer_pkg.sv
// seq_serializer_pkg: shared FSM encodings, idle line level and counter sizing for seq_serializer (optional SEQ_SERIALIZER_PARITY_EN build)
package seq_serializer_pkg;
  localparam logic [1:0] SEQ_ST_IDLE   = 2'b00;
  localparam logic [1:0] SEQ_ST_SHIFT  = 2'b01;
  localparam logic [1:0] SEQ_ST_PARITY = 2'b10;
  localparam logic SEQ_IDLE_LEVEL = 1'b1;
  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction
endpackage

// File: rtl/seq_serializer_bit_counter.sv
// seq_bit_counter: loadable down-counter whose last flag marks the final data bit of a frame
module seq_bit_counter
  import seq_serializer_pkg::*;
#(
  parameter int CW = 3
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          load_i,
  input  logic [CW-1:0] value_i,
  input  logic          dec_i,
  output logic          last_o
);
  logic [CW-1:0] count_q, count_d;
  // load wins over decrement; otherwise hold
  always_comb count_d = load_i ? value_i : dec_i ? count_q - 1'b1 : count_q;
  // counter register
  always_ff @(posedge clock) begin
    if (!reset_n) count_q <= '0;
    else count_q <= count_d;
  end
  assign last_o = (count_q == '0);
endmodule

// File: rtl/seq_serializer.sv
// seq_serializer: valid/ready word to MSB-first serial stream, idle-high line; SEQ_SERIALIZER_PARITY_EN appends an even-parity bit
module seq_serializer
  import seq_serializer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             seq,
  output logic             busy,
  output logic             frame_done,
  output logic [1:0]       state
);
  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
  logic [1:0] state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d, sr_sh;
  logic seq_q, seq_d, done_q, done_d;
  logic last, in_shift, final_cyc, accept;
  assign in_shift  = (state_q == SEQ_ST_SHIFT);
  assign sr_sh     = sr_q << 1;
  assign load_ready = (state_q == SEQ_ST_IDLE) || final_cyc;
  assign accept    = load_valid && load_ready;
  seq_bit_counter #(.CW(CW)) u_cnt (
    .clock  (clock),
    .reset_n(reset_n),
    .load_i (accept),
    .value_i(LAST_IDX),
    .dec_i  (in_shift && !last && !accept),
    .last_o (last)
  );
`ifdef SEQ_SERIALIZER_PARITY_EN
  logic par_q, par_d, in_par;
  assign in_par    = (state_q == SEQ_ST_PARITY);
  assign final_cyc = in_par;
  // parity captured with the word; last data bit hands over to the parity cycle
  always_comb begin
    par_d   = accept ? ^load_data : par_q;
    state_d = accept ? SEQ_ST_SHIFT : (in_shift && last) ? SEQ_ST_PARITY : in_par ? SEQ_ST_IDLE : state_q;
    seq_d   = accept ? load_data[WIDTH-1] : in_shift ? (last ? par_q : sr_sh[WIDTH-1]) : SEQ_IDLE_LEVEL;
  end
  // parity register
  always_ff @(posedge clock) begin
    if (!reset_n) par_q <= 1'b0;
    else par_q <= par_d;
  end
`else
  assign final_cyc = in_shift && last;
  // next state and next serial bit; a final-cycle accept restarts SHIFT with no gap
  always_comb begin
    state_d = accept ? SEQ_ST_SHIFT : final_cyc ? SEQ_ST_IDLE : state_q;
    seq_d   = accept ? load_data[WIDTH-1] : (in_shift && !last) ? sr_sh[WIDTH-1] : SEQ_IDLE_LEVEL;
  end
`endif
  // shift register and done pulse
  always_comb begin
    sr_d   = accept ? load_data : in_shift ? sr_sh : sr_q;
    done_d = final_cyc;
  end
  // state, data and output registers
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= SEQ_ST_IDLE;
      sr_q    <= '0;
      seq_q   <= SEQ_IDLE_LEVEL;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      seq_q   <= seq_d;
      done_q  <= done_d;
    end
  end
  assign seq        = seq_q;
  assign busy       = (state_q != SEQ_ST_IDLE);
  assign frame_done = done_q;
  assign state      = state_q;
endmodule
